// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encoding, drain counter
// width and the bundle of control outputs driven each cycle.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int DRAIN_CNT_W = 3;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
      logic halted;
   } ctrl_t;

   localparam ctrl_t CTRL_OFF = '0;

   // Normal forward progress: every register advances, nothing is squashed.
   function automatic ctrl_t ctrl_run();
      ctrl_t c;
      c           = CTRL_OFF;
      c.pc_en     = 1'b1;
      c.if_id_en  = 1'b1;
      c.id_ex_en  = 1'b1;
      c.ex_mem_en = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX hazard inputs from the datapath, pipeline register
// enables/flushes and performance counters back to it.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1_ID;
   logic [4:0]       rs2_ID;
   logic             uses_rs2_ID;
   logic [4:0]       rd_EX;
   logic             mem_rd_EX;
   logic             redirect_EX;
   logic             hlt_EX;
   logic             dmem_wait;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             ex_mem_en;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  rs1_ID, rs2_ID, uses_rs2_ID, rd_EX, mem_rd_EX, redirect_EX, hlt_EX, dmem_wait,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted,
      output stall_cnt, flush_cnt
   );

   modport slave (
      output rs1_ID, rs2_ID, uses_rs2_ID, rd_EX, mem_rd_EX, redirect_EX, hlt_EX, dmem_wait,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted,
      input  stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module load_use_detect (
   input  logic [4:0] rs1_id,
   input  logic [4:0] rs2_id,
   input  logic       uses_rs2_id,
   input  logic [4:0] rd_ex,
   input  logic       mem_rd_ex,
   output logic       lu_stall
);

   // $0 is hardwired to zero, so a load targeting it never creates a dependency.
   always_comb begin
      lu_stall = mem_rd_ex && (rd_ex != 5'd0) &&
                 ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: stall/flush/freeze priority and the hlt drain FSM.
// Define PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.master hz
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   state_t                 state, state_nxt;
   logic [DRAIN_CNT_W-1:0] cnt, cnt_nxt;
   ctrl_t                  ctrl;
   logic                   lu_stall;

   load_use_detect u_lud (
      .rs1_id      (hz.rs1_ID),
      .rs2_id      (hz.rs2_ID),
      .uses_rs2_id (hz.uses_rs2_ID),
      .rd_ex       (hz.rd_EX),
      .mem_rd_ex   (hz.mem_rd_EX),
      .lu_stall    (lu_stall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Exactly one rule applies per cycle; any flushed register keeps its enable high.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ctrl      = CTRL_OFF;
      case (state)
         RUN: begin
            if (hz.dmem_wait) begin
               ctrl = CTRL_OFF;
            end else if (hz.hlt_EX) begin
               state_nxt        = DRAIN;
               cnt_nxt          = DRAIN_INIT;
               ctrl             = ctrl_run();
               ctrl.pc_en       = 1'b0;
               ctrl.if_id_flush = 1'b1;
               ctrl.id_ex_flush = 1'b1;
            end else if (hz.redirect_EX) begin
               ctrl             = ctrl_run();
               ctrl.if_id_flush = 1'b1;
               ctrl.id_ex_flush = 1'b1;
            end else if (lu_stall) begin
               ctrl             = ctrl_run();
               ctrl.pc_en       = 1'b0;
               ctrl.if_id_en    = 1'b0;
               ctrl.id_ex_flush = 1'b1;
            end else begin
               ctrl = ctrl_run();
            end
         end
         DRAIN: begin
            ctrl.if_id_en    = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_en    = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            ctrl.ex_mem_en   = !hz.dmem_wait;
            if (!hz.dmem_wait) begin
               if (cnt == '0) state_nxt = HALTED;
               else           cnt_nxt   = cnt - DRAIN_CNT_W'(1);
            end
         end
         HALTED: begin
            ctrl.halted = 1'b1;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
      if (reset) ctrl = CTRL_OFF;
   end

   assign hz.pc_en       = ctrl.pc_en;
   assign hz.if_id_en    = ctrl.if_id_en;
   assign hz.if_id_flush = ctrl.if_id_flush;
   assign hz.id_ex_en    = ctrl.id_ex_en;
   assign hz.id_ex_flush = ctrl.id_ex_flush;
   assign hz.ex_mem_en   = ctrl.ex_mem_en;
   assign hz.halted      = ctrl.halted;

`ifdef PERF_CNT_EN
   logic             stall_evt, flush_evt;
   logic [CNT_W-1:0] stall_q, flush_q;

   assign stall_evt = (state == RUN) &&
                      (hz.dmem_wait || (!hz.hlt_EX && !hz.redirect_EX && lu_stall));
   assign flush_evt = (state == RUN) && !hz.dmem_wait && !hz.hlt_EX && hz.redirect_EX;

   // Counters saturate rather than wrap so long runs never report a misleadingly small value.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
         if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign hz.stall_cnt = stall_q;
   assign hz.flush_cnt = flush_q;
`else
   assign hz.stall_cnt = {CNT_W{1'b0}};
   assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of single-cycle RUN vectors, then
// hand-written freeze, drain, halt and reset sequences.
module tb_pipeline_hazard_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   always #5 clk = ~clk;

`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Expected control order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted}
   localparam logic [6:0] C_RUN    = 7'b1101010;
   localparam logic [6:0] C_LU     = 7'b0001110;
   localparam logic [6:0] C_REDIR  = 7'b1111110;
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_DRAIN  = 7'b0111110;
   localparam logic [6:0] C_DRAINW = 7'b0111100;
   localparam logic [6:0] C_HALT   = 7'b0000001;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses_rs2;
      logic [4:0] rd;
      logic       mem_rd;
      logic       redirect;
      logic       hlt;
      logic       wt;
      logic [6:0] exp;
      int         stall_inc;
      int         flush_inc;
      string      name;
   } vec_t;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_stall = 0;
   int exp_flush = 0;
   vec_t table_v[11];

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                               input logic [4:0] rd, input logic mem_rd, input logic redirect,
                               input logic hlt, input logic wt, input logic [6:0] exp,
                               input int si, input int fi, input string name);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.uses_rs2 = uses; v.rd = rd; v.mem_rd = mem_rd;
      v.redirect = redirect; v.hlt = hlt; v.wt = wt; v.exp = exp;
      v.stall_inc = si; v.flush_inc = fi; v.name = name;
      return v;
   endfunction

   function automatic logic [31:0] cntExp(input int v);
      return PERF ? 32'(v) : 32'd0;
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset          = 1'b0;
      hz.rs1_ID      = v.rs1;
      hz.rs2_ID      = v.rs2;
      hz.uses_rs2_ID = v.uses_rs2;
      hz.rd_EX       = v.rd;
      hz.mem_rd_EX   = v.mem_rd;
      hz.redirect_EX = v.redirect;
      hz.hlt_EX      = v.hlt;
      hz.dmem_wait   = v.wt;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic checkCtrl(input string name, input logic [6:0] exp);
      checkOutput(name, 32'({hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
                             hz.id_ex_flush, hz.ex_mem_en, hz.halted}), 32'(exp));
   endtask

   task automatic checkCounters(input string name);
      checkOutput({name, "_stall_cnt"}, hz.stall_cnt, cntExp(exp_stall));
      checkOutput({name, "_flush_cnt"}, hz.flush_cnt, cntExp(exp_flush));
   endtask

   // Counters seen this cycle reflect earlier cycles; this cycle's effect is added afterwards.
   task automatic runVec(input vec_t v);
      applyStimulus(v);
      checkCtrl(v.name, v.exp);
      checkCounters(v.name);
      exp_stall += v.stall_inc;
      exp_flush += v.flush_inc;
   endtask

   task automatic pulseReset(input string name);
      @(negedge clk);
      reset          = 1'b1;
      hz.rs1_ID      = 5'd0;
      hz.rs2_ID      = 5'd0;
      hz.uses_rs2_ID = 1'b0;
      hz.rd_EX       = 5'd0;
      hz.mem_rd_EX   = 1'b0;
      hz.redirect_EX = 1'b1;
      hz.hlt_EX      = 1'b1;
      hz.dmem_wait   = 1'b0;
      #1;
      checkCtrl(name, C_FREEZE);
      exp_stall = 0;
      exp_flush = 0;
   endtask

   initial begin
      hz.rs1_ID = 5'd0; hz.rs2_ID = 5'd0; hz.uses_rs2_ID = 1'b0; hz.rd_EX = 5'd0;
      hz.mem_rd_EX = 1'b0; hz.redirect_EX = 1'b0; hz.hlt_EX = 1'b0; hz.dmem_wait = 1'b0;

      //                rs1   rs2   use   rd    lw    redir hlt   wait  expect    si fi
      table_v[0]  = mk(5'd1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN,    0, 0, "no_hazard");
      table_v[1]  = mk(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,     1, 0, "lu_rs1");
      table_v[2]  = mk(5'd3, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    0, 0, "after_bubble");
      table_v[3]  = mk(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN,    0, 0, "lw_r0");
      table_v[4]  = mk(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,     1, 0, "lu_sw_rs2");
      table_v[5]  = mk(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN,    0, 0, "rs2_unused");
      table_v[6]  = mk(5'd6, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,    0, 0, "not_load");
      table_v[7]  = mk(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, C_REDIR,  0, 1, "redir_over_lu");
      table_v[8]  = mk(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, C_FREEZE, 1, 0, "wait_over_lu");
      table_v[9]  = mk(5'd1, 5'd4, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, C_FREEZE, 1, 0, "wait_over_redir");
      table_v[10] = mk(5'd1, 5'd4, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, C_REDIR,  0, 1, "redirect");

      @(negedge clk);
      #1;
      checkCtrl("reset_outputs", C_FREEZE);
      checkCounters("reset");

      for (int i = 0; i < 11; i++) runVec(table_v[i]);

      // Three frozen cycles hold the redirect, which is then applied exactly once.
      for (int i = 0; i < 3; i++)
         runVec(mk(5'd1, 5'd4, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, C_FREEZE, 1, 0, "wait_hold_redir"));
      runVec(mk(5'd1, 5'd4, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, C_REDIR, 0, 1, "redir_after_wait"));
      runVec(mk(5'd1, 5'd4, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   0, 0, "run_after_redir"));

      // Plain drain: hlt cycle, two drain cycles, halted on the third; redirect/load-use ignored.
      runVec(mk(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, C_DRAIN, 0, 0, "hlt_enter"));
      runVec(mk(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, C_DRAIN, 0, 0, "drain1_ign_redir"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DRAIN, 0, 0, "drain2"));
      runVec(mk(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, C_HALT,  0, 0, "halted"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_HALT,  0, 0, "halted_sticky"));

      pulseReset("reset_while_halted");
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 0, 0, "run_after_reset"));

      // A dmem_wait mid-drain stretches the drain by one cycle and is not counted as a stall.
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_DRAIN,  0, 0, "hlt_enter_w"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DRAIN,  0, 0, "drain1_w"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRAINW, 0, 0, "drain_wait"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DRAIN,  0, 0, "drain2_w"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_HALT,   0, 0, "halted_w"));

      pulseReset("reset_halted_2");
      runVec(mk(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,    1, 0, "lu_after_reset"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_DRAIN, 0, 0, "hlt_enter_r"));
      pulseReset("reset_mid_drain");
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   0, 0, "run_after_drain_rst"));
      runVec(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   0, 0, "run_steady"));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
